// File: rtl/clock_lock_sequencer.sv
// clock_lock_sequencer
// Brings up a chain of cascaded clock primitives (PLL -> DCM -> ...) one stage
// at a time. A stage leaves reset only once every stage upstream of it has
// locked and settled. A stage that fails to lock in time is retried a bounded
// number of times. A lock loss rewinds the chain only from the lowest lost stage.
//
// Ports:
//   clk          free-running reference clock (also feeds the first primitive)
//   rst_n        asynchronous active-low reset
//   restart      one-cycle synchronous request to re-sequence from stage 0
//   stage_locked raw LOCKED outputs of the primitives (asynchronous to clk)
//   stage_rst    active-high reset to each primitive, bit 0 = first stage
//   ready        every stage locked and settled
//   failed       sticky, set when a stage has exhausted its retries
//   fail_stage   index of the failing stage, valid while failed=1
//   cur_stage    stage currently being brought up (debug)
module clock_lock_sequencer #(
  parameter int N_STAGES      = 3,
  parameter int SYNC_DEPTH    = 2,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  input  logic [N_STAGES-1:0] stage_locked,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                ready,
  output logic                failed,
  output logic [2:0]          fail_stage,
  output logic [2:0]          cur_stage
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int RW        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT,
    ST_SETTLE,
    ST_RUN,
    ST_FAILED
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [RW-1:0]       retries, retries_n;
  logic [2:0]          cur, cur_n;
  logic [N_STAGES-1:0] stage_rst_n;
  logic                ready_n, failed_n;
  logic [2:0]          fail_stage_n;

  logic [N_STAGES-1:0] sync_q [SYNC_DEPTH];
  logic [N_STAGES-1:0] lock_s;

  logic                cur_lock, up_loss, any_loss;
  logic [2:0]          loss_idx;
  logic [N_STAGES-1:0] cur_bit, cur_mask, rew_mask;
  logic                timeout, rewind;

  // Lock synchronisers; every decision below uses lock_s only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= stage_locked;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign lock_s    = sync_q[SYNC_DEPTH-1];
  assign cur_stage = cur;

  // Per-stage decode. The loop runs downwards so the lowest lost stage wins.
  always_comb begin
    cur_lock = 1'b0;
    up_loss  = 1'b0;
    any_loss = 1'b0;
    loss_idx = '0;
    cur_bit  = '0;
    cur_mask = '0;
    rew_mask = '0;
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (3'(k) == cur) begin
        cur_lock   = lock_s[k];
        cur_bit[k] = 1'b1;
      end
      if (3'(k) >= cur) cur_mask[k] = 1'b1;
      if (!lock_s[k]) begin
        any_loss = 1'b1;
        loss_idx = 3'(k);
        if (3'(k) < cur) up_loss = 1'b1;
      end
    end
    for (int k = 0; k < N_STAGES; k++) begin
      if (3'(k) >= loss_idx) rew_mask[k] = 1'b1;
    end
  end

  // Next-state logic. Priority: restart > upstream loss > current-stage events.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    retries_n    = retries;
    cur_n        = cur;
    stage_rst_n  = stage_rst;
    ready_n      = ready;
    failed_n     = failed;
    fail_stage_n = fail_stage;
    timeout      = 1'b0;
    rewind       = 1'b0;

    case (state)
      ST_HOLD: begin
        stage_rst_n = stage_rst | cur_mask;
        if (cnt == CW'(RST_CYCLES - 1)) begin
          stage_rst_n = (stage_rst | cur_mask) & ~cur_bit;
          cnt_n       = '0;
          state_n     = ST_WAIT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_WAIT: begin
        if (up_loss) begin
          rewind = 1'b1;
        end else if (cur_lock) begin
          cnt_n   = '0;
          state_n = ST_SETTLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          timeout = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_SETTLE: begin
        // A glitch on the current lock during settle counts as a failed attempt.
        if (up_loss) begin
          rewind = 1'b1;
        end else if (!cur_lock) begin
          timeout = 1'b1;
        end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          cnt_n = '0;
          if (cur == 3'(N_STAGES - 1)) begin
            ready_n = 1'b1;
            state_n = ST_RUN;
          end else begin
            cur_n     = cur + 3'd1;
            retries_n = '0;
            state_n   = ST_HOLD;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (any_loss) rewind = 1'b1;
      end
      ST_FAILED: begin
      end
      default: state_n = ST_HOLD;
    endcase

    // Rewind from the lowest lost stage; stages below it keep running.
    if (rewind) begin
      cur_n       = loss_idx;
      stage_rst_n = stage_rst | rew_mask;
      ready_n     = 1'b0;
      retries_n   = '0;
      cnt_n       = '0;
      state_n     = ST_HOLD;
    end

    if (timeout) begin
      cnt_n = '0;
      if (retries < RW'(MAX_RETRIES)) begin
        retries_n   = retries + RW'(1);
        stage_rst_n = stage_rst | cur_bit;
        state_n     = ST_HOLD;
      end else begin
        failed_n     = 1'b1;
        fail_stage_n = cur;
        stage_rst_n  = stage_rst | cur_mask;
        ready_n      = 1'b0;
        state_n      = ST_FAILED;
      end
    end

    if (restart) begin
      state_n     = ST_HOLD;
      cnt_n       = '0;
      retries_n   = '0;
      cur_n       = '0;
      stage_rst_n = '1;
      ready_n     = 1'b0;
      failed_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      retries    <= '0;
      cur        <= '0;
      stage_rst  <= '1;
      ready      <= 1'b0;
      failed     <= 1'b0;
      fail_stage <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retries    <= retries_n;
      cur        <= cur_n;
      stage_rst  <= stage_rst_n;
      ready      <= ready_n;
      failed     <= failed_n;
      fail_stage <= fail_stage_n;
    end
  end

endmodule
